double_max: RTL and testbench

//  Registered IEEE-754 binary64 maximum: z <= max(a, b) every clock.

---
 rtl/double_max.sv | 75 +++++++
 tb/tb_double_max.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/double_max.sv
// rtl/double_max.sv - registered IEEE-754 binary64 maximum, one result per clock
module double_max (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] z
);

    localparam logic [63:0] CANON_QNAN = 64'h7FF8_0000_0000_0000;

    logic        a_sign;
    logic        b_sign;
    logic [10:0] a_exp;
    logic [10:0] b_exp;
    logic [51:0] a_frac;
    logic [51:0] b_frac;
    logic [62:0] a_mag;
    logic [62:0] b_mag;
    logic        a_nan;
    logic        b_nan;
    logic        pick_b;
    logic [63:0] max_next;

    assign a_sign = a[63];
    assign b_sign = b[63];
    assign a_exp  = a[62:52];
    assign b_exp  = b[62:52];
    assign a_frac = a[51:0];
    assign b_frac = b[51:0];
    assign a_mag  = a[62:0];
    assign b_mag  = b[62:0];

    // NaN is an all-ones exponent with a non-zero fraction; quiet/signalling does not matter here
    assign a_nan = (a_exp == 11'h7FF) && (a_frac != 52'h0);
    assign b_nan = (b_exp == 11'h7FF) && (b_frac != 52'h0);

    // Ordering on sign-magnitude; ties (identical patterns) keep a, and +0 beats -0 via the sign rule
    always_comb begin
        pick_b = 1'b0;
        if (a_sign != b_sign) begin
            pick_b = a_sign;
        end else if (a_sign) begin
            pick_b = (b_mag < a_mag);
        end else begin
            pick_b = (b_mag > a_mag);
        end
    end

    // NaN handling overrides ordering; a single NaN yields the other operand untouched
    always_comb begin
        max_next = a;
        if (a_nan && b_nan) begin
            max_next = CANON_QNAN;
        end else if (a_nan) begin
            max_next = b;
        end else if (b_nan) begin
            max_next = a;
        end else if (pick_b) begin
            max_next = b;
        end else begin
            max_next = a;
        end
    end

    // Output register; reset clears to +0.0 regardless of clock or operand values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z <= 64'h0;
        end else begin
            z <= max_next;
        end
    end

endmodule

// File: tb/tb_double_max.sv
// tb/tb_double_max.sv - scoreboard bench for double_max
module tb_double_max;

    logic        clk;
    logic        rst_n;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] z;

    logic [63:0] exp_q[$];
    string       name_q[$];
    int          checks;
    int          errors;

    double_max dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .z     (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic is_nan(input logic [63:0] v);
        return (v[62:52] == 11'h7FF) && (v[51:0] != 52'h0);
    endfunction

    // Reference: map each pattern to an unsigned key whose order is the value order
    function automatic logic [63:0] ref_max(input logic [63:0] x, input logic [63:0] y);
        logic [63:0] kx;
        logic [63:0] ky;
        if (is_nan(x) && is_nan(y)) return 64'h7FF8_0000_0000_0000;
        if (is_nan(x)) return y;
        if (is_nan(y)) return x;
        kx = x[63] ? ~x : (x | 64'h8000_0000_0000_0000);
        ky = y[63] ? ~y : (y | 64'h8000_0000_0000_0000);
        return (ky > kx) ? y : x;
    endfunction

    // Monitor: each cycle just after the edge, compare z with the oldest outstanding expectation
    initial begin
        logic [63:0] e;
        string       n;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check(n, z, e);
            end
        end
    end

    task automatic apply(input string name, input logic [63:0] va, input logic [63:0] vb,
                         input logic [63:0] ve);
        @(posedge clk);
        #2;
        a = va;
        b = vb;
        exp_q.push_back(ve);
        name_q.push_back(name);
    endtask

    logic [63:0] specials [12];

    function automatic logic [63:0] rnd_op();
        logic [63:0] v;
        if ($urandom_range(0, 3) == 0) begin
            v = specials[$urandom_range(0, 11)];
        end else begin
            v = {$urandom(), $urandom()};
        end
        return v;
    endfunction

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        checks = 0;
        errors = 0;
        specials[0]  = 64'h0000_0000_0000_0000;
        specials[1]  = 64'h8000_0000_0000_0000;
        specials[2]  = 64'h7FF0_0000_0000_0000;
        specials[3]  = 64'hFFF0_0000_0000_0000;
        specials[4]  = 64'h7FF8_0000_0000_0000;
        specials[5]  = 64'h7FF0_0000_0000_0001;
        specials[6]  = 64'hFFF8_0000_0000_0001;
        specials[7]  = 64'h0000_0000_0000_0001;
        specials[8]  = 64'h8000_0000_0000_0001;
        specials[9]  = 64'h3FF0_0000_0000_0000;
        specials[10] = 64'hBFF0_0000_0000_0000;
        specials[11] = 64'h7FEF_FFFF_FFFF_FFFF;

        // Reset with valid operands, then with X operands
        rst_n = 1'b1;
        a = 64'h4008_0000_0000_0000;
        b = 64'h4014_0000_0000_0000;
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_async", z, 64'h0);
        @(posedge clk);
        #2;
        check("reset_hold", z, 64'h0);
        a = 'x;
        b = 'x;
        @(posedge clk);
        #2;
        check("reset_x_inputs", z, 64'h0);

        // Release: z stays 0 until the first edge, then shows max(3.0, 5.0)
        a = 64'h4008_0000_0000_0000;
        b = 64'h4014_0000_0000_0000;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        exp_q.push_back(64'h4014_0000_0000_0000);
        name_q.push_back("release_first");
        #1;
        check("release_hold", z, 64'h0);

        apply("neg_vs_pos",     64'hC000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000);
        apply("both_neg",       64'hBFF0_0000_0000_0000, 64'hC000_0000_0000_0000, 64'hBFF0_0000_0000_0000);
        apply("both_pos",       64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000);
        apply("nzero_pzero",    64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000);
        apply("pzero_nzero",    64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000);
        apply("nzero_nzero",    64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        apply("subnormal",      64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0001);
        apply("neg_subnormal",  64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        apply("qnan_a",         64'h7FF8_0000_0000_0001, 64'hC000_0000_0000_0000, 64'hC000_0000_0000_0000);
        apply("snan_b",         64'h3FF0_0000_0000_0000, 64'h7FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000);
        apply("both_snan",      64'h7FF0_0000_0000_0001, 64'h7FF0_0000_0000_0001, 64'h7FF8_0000_0000_0000);
        apply("both_nan_mixed", 64'h7FF8_0000_0000_0000, 64'hFFF8_0000_0000_0001, 64'h7FF8_0000_0000_0000);
        apply("ninf_vs_max",    64'hFFF0_0000_0000_0000, 64'hFFEF_FFFF_FFFF_FFFF, 64'hFFEF_FFFF_FFFF_FFFF);
        apply("pinf_a",         64'h7FF0_0000_0000_0000, 64'h7FEF_FFFF_FFFF_FFFF, 64'h7FF0_0000_0000_0000);
        apply("pinf_b",         64'hC000_0000_0000_0000, 64'h7FF0_0000_0000_0000, 64'h7FF0_0000_0000_0000);
        apply("pinf_vs_nan",    64'h7FFF_FFFF_FFFF_FFFF, 64'h7FF0_0000_0000_0000, 64'h7FF0_0000_0000_0000);
        apply("equal_pattern",  64'h4014_0000_0000_0000, 64'h4014_0000_0000_0000, 64'h4014_0000_0000_0000);
        apply("ninf_ninf",      64'hFFF0_0000_0000_0000, 64'hFFF0_0000_0000_0000, 64'hFFF0_0000_0000_0000);

        // Streaming random pairs with one reset in the middle
        for (int i = 0; i < 5000; i++) begin
            if (i == 2500) begin
                @(posedge clk);
                #2;
                exp_q.delete();
                name_q.delete();
                rst_n = 1'b0;
                #1;
                check("mid_reset_async", z, 64'h0);
                @(posedge clk);
                #1;
                check("mid_reset_hold", z, 64'h0);
                #1;
                rst_n = 1'b1;
                exp_q.push_back(ref_max(a, b));
                name_q.push_back("mid_reset_release");
            end
            ra = rnd_op();
            rb = rnd_op();
            apply("stream", ra, rb, ref_max(ra, rb));
        end

        @(posedge clk);
        @(posedge clk);
        #3;
        check("queue_drained", 64'(exp_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
